// File: rtl/pc_predict_unit.sv
// Fetch-stage program counter with a direct-mapped branch target buffer.
// Next-PC priority: redirect, stall hold, BTB prediction, sequential increment.
// Optional redirect performance counter enabled by the PC_PERF_CNT_EN macro.
module pc_predict_unit #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int unsigned        INC       = 4,
    parameter int unsigned        BTB_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_pc_src,
    input  logic [ADDR_W-1:0] i_result,
    input  logic              i_update_en,
    input  logic [ADDR_W-1:0] i_update_pc,
    input  logic [ADDR_W-1:0] i_update_target,
    input  logic              i_update_taken,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus_4,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_pred_target,
    output logic [31:0]       o_redirect_count
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // BTB storage; only valid bits and counters need a reset value.
    logic [BTB_DEPTH-1:0] r_valid;
    logic [1:0]           r_ctr    [BTB_DEPTH];
    logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
    logic [ADDR_W-1:0]    r_target [BTB_DEPTH];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;

    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [1:0]       w_up_ctr;

    // Low address bits of the update PC never reach the BTB.
    logic w_unused;
    assign w_unused = ^i_update_pc[1:0];

    assign w_lk_idx = r_pc[IDX_W+1:2];
    assign w_lk_tag = r_pc[ADDR_W-1:IDX_W+2];
    assign w_up_idx = i_update_pc[IDX_W+1:2];
    assign w_up_tag = i_update_pc[ADDR_W-1:IDX_W+2];

    // Combinational lookup on the current PC and the update address.
    always_comb begin
        w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        o_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
        o_pred_target = w_lk_hit ? r_target[w_lk_idx] : '0;
        w_up_hit      = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
        w_up_ctr      = r_ctr[w_up_idx];
        if (i_update_taken) begin
            if (w_up_ctr != 2'b11) w_up_ctr = w_up_ctr + 2'b01;
        end else begin
            if (w_up_ctr != 2'b00) w_up_ctr = w_up_ctr - 2'b01;
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_plus_4 = r_pc + ADDR_W'(INC);

    // Next-PC select; redirect overrides stall, result is word-aligned.
    always_comb begin
        w_pc_next = o_pc_plus_4;
        if (i_pc_src) begin
            w_pc_next = i_result;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end else if (o_pred_taken) begin
            w_pc_next = o_pred_target;
        end
        w_pc_next = w_pc_next & ALIGN_MASK;
    end

    // PC register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC & ALIGN_MASK;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Valid bits and saturating counters; a not-taken miss leaves the entry alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(BTB_DEPTH); i++) begin
                r_ctr[i] <= 2'b00;
            end
        end else if (i_update_en) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_up_ctr;
            end else if (i_update_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target written on every taken update (tag is unchanged on a hit).
    always_ff @(posedge i_clk) begin
        if (i_update_en && i_update_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= i_update_target;
        end
    end

`ifdef PC_PERF_CNT_EN
    logic [31:0] r_redirect_cnt;

    // Saturating count of redirect cycles, stalled or not.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_cnt <= '0;
        end else if (i_pc_src && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign o_redirect_count = r_redirect_cnt;
`else
    assign o_redirect_count = '0;
`endif

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed, table-driven bench for pc_predict_unit (default parameters).
module tb_pc_predict_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        pc_src;
    logic [31:0] result;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_tgt;
    logic        upd_taken;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] redirect_count;

    pc_predict_unit dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_stall          (stall),
        .i_pc_src         (pc_src),
        .i_result         (result),
        .i_update_en      (upd_en),
        .i_update_pc      (upd_pc),
        .i_update_target  (upd_tgt),
        .i_update_taken   (upd_taken),
        .o_pc             (pc),
        .o_pc_plus_4      (pc_plus_4),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .o_redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        pc_src;
        logic [31:0] result;
        logic        upd_en;
        logic [31:0] upd_pc;
        logic [31:0] upd_tgt;
        logic        upd_taken;
        logic [31:0] exp_pc;
        logic        exp_pt;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef PC_PERF_CNT_EN
        return 32'(exp_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic add(input logic st, input logic ps, input logic [31:0] res,
                       input logic ue, input logic [31:0] up, input logic [31:0] ut,
                       input logic uk, input logic [31:0] epc, input logic ept,
                       input logic [31:0] etg);
        vec_t v;
        v.stall = st; v.pc_src = ps; v.result = res;
        v.upd_en = ue; v.upd_pc = up; v.upd_tgt = ut; v.upd_taken = uk;
        v.exp_pc = epc; v.exp_pt = ept; v.exp_tgt = etg;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        stall = 0; pc_src = 0; result = '0;
        upd_en = 0; upd_pc = '0; upd_tgt = '0; upd_taken = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] epc, input logic ept,
                               input logic [31:0] etg);
        check({tag, " pc"}, pc, epc);
        check({tag, " pc_plus_4"}, pc_plus_4, epc + 32'd4);
        check({tag, " pred_taken"}, 32'(pred_taken), 32'(ept));
        check({tag, " pred_target"}, pred_target, etg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // stall, pc_src, result, upd_en, upd_pc, upd_tgt, upd_taken, exp_pc, exp_pt, exp_tgt
        add(0, 0, 0,            0, 0,    0,     0, 32'h4,        0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'h8,        0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'hC,        0, 0);
        add(0, 1, 32'h2914AB4E, 0, 0,    0,     0, 32'h2914AB4C, 0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'h2914AB50, 0, 0);
        // Allocate 0x10 -> 0x100 while redirecting to 0.
        add(0, 1, 0,            1, 'h10, 'h100, 1, 32'h0,        0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'h4,        0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'h8,        0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'hC,        0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'h10,       1, 32'h100);
        add(0, 0, 0,            0, 0,    0,     0, 32'h100,      0, 0);
        // Not-taken training: 10 -> 01 -> 00 -> 00.
        add(0, 0, 0,            1, 'h10, 0,     0, 32'h104,      0, 0);
        add(0, 0, 0,            1, 'h10, 0,     0, 32'h108,      0, 0);
        add(0, 0, 0,            1, 'h10, 0,     0, 32'h10C,      0, 0);
        add(0, 1, 32'h10,       0, 0,    0,     0, 32'h10,       0, 32'h100);
        add(0, 0, 0,            0, 0,    0,     0, 32'h14,       0, 0);
        add(0, 1, 32'h50,       0, 0,    0,     0, 32'h50,       0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'h54,       0, 0);
        // Stall hold; allocation of 0x20 during stall; redirect beats stall.
        add(0, 1, 32'h8,        0, 0,    0,     0, 32'h8,        0, 0);
        add(1, 0, 0,            0, 0,    0,     0, 32'h8,        0, 0);
        add(1, 0, 0,            1, 'h20, 'h300, 1, 32'h8,        0, 0);
        add(1, 0, 0,            0, 0,    0,     0, 32'h8,        0, 0);
        add(1, 1, 32'h40,       0, 0,    0,     0, 32'h40,       0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'h44,       0, 0);
        // Taken training to saturation 00->01->10->11->11, then 11->10->01.
        add(0, 0, 0,            1, 'h10, 'h100, 1, 32'h48,       0, 0);
        add(0, 0, 0,            1, 'h10, 'h100, 1, 32'h4C,       0, 0);
        add(0, 0, 0,            1, 'h10, 'h100, 1, 32'h50,       0, 0);
        add(0, 0, 0,            1, 'h10, 'h100, 1, 32'h54,       0, 0);
        add(0, 0, 0,            1, 'h10, 0,     0, 32'h58,       0, 0);
        add(0, 0, 0,            1, 'h10, 0,     0, 32'h5C,       0, 0);
        add(0, 1, 32'h10,       0, 0,    0,     0, 32'h10,       0, 32'h100);
        // Same-index update and lookup: old contents steer this cycle.
        add(0, 0, 0,            1, 'h10, 'h200, 1, 32'h14,       0, 0);
        add(0, 1, 32'h10,       0, 0,    0,     0, 32'h10,       1, 32'h200);
        add(0, 0, 0,            0, 0,    0,     0, 32'h200,      0, 0);
        // Address wrap.
        add(0, 1, 32'hFFFFFFFC, 0, 0,    0,     0, 32'hFFFFFFFC, 0, 0);
        add(0, 0, 0,            0, 0,    0,     0, 32'h0,        0, 0);
        add(0, 1, 32'h20,       0, 0,    0,     0, 32'h20,       1, 32'h300);
        add(0, 0, 0,            0, 0,    0,     0, 32'h300,      0, 0);

        // Reset held for two edges, released mid-cycle.
        idle_inputs();
        rst_n = 0;
        step();
        step();
        check_state("reset", 32'h0, 0, 32'h0);
        check("reset count", redirect_count, 32'd0);
        #3 rst_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            stall     = vecs[i].stall;
            pc_src    = vecs[i].pc_src;
            result    = vecs[i].result;
            upd_en    = vecs[i].upd_en;
            upd_pc    = vecs[i].upd_pc;
            upd_tgt   = vecs[i].upd_tgt;
            upd_taken = vecs[i].upd_taken;
            step();
            if (vecs[i].pc_src) exp_cnt++;
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pt,
                        vecs[i].exp_tgt);
            check($sformatf("vec%0d count", i), redirect_count, cnt_exp());
        end

        // Asynchronous reset mid-cycle at PC 0x100, with an update pending.
        idle_inputs();
        pc_src = 1; result = 32'h100;
        step();
        exp_cnt++;
        check("pre-reset pc", pc, 32'h100);
        idle_inputs();
        upd_en = 1; upd_pc = 32'h20; upd_tgt = 32'h400; upd_taken = 1;
        #3 rst_n = 0;
        #1;
        check_state("async reset", 32'h0, 0, 32'h0);
        check("async reset count", redirect_count, 32'd0);
        exp_cnt = 0;
        step();
        #2;
        idle_inputs();
        rst_n = 1;
        step();
        check_state("post 4", 32'h4, 0, 32'h0);
        step();
        step();
        step();
        check_state("post 10", 32'h10, 0, 32'h0);
        step();
        check_state("post 14", 32'h14, 0, 32'h0);
        step();
        step();
        step();
        check_state("post 20", 32'h20, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Parametrised fetch-stage program counter. Successor to the single-redirect ProgramCounter.
Adds pipeline stall hold, a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and next-PC selection driven by prediction.
Sits in front of the instruction cache. Execute-stage branch resolution feeds redirect and BTB-update inputs.

Parameters:
ADDR_W, 32, PC/address width in bits.
RESET_PC, 32'h0000_0000, PC value on reset.
INC, 4, sequential increment in bytes.
BTB_DEPTH, 16, number of BTB entries; power of 2, minimum 2; IDX_W = log2(BTB_DEPTH).

Ports:
CLK  in  1  clock; rising edge.
Reset  in  1  asynchronous, active-low reset.
Stall  in  1  hold PC (fetch stall).
PCSrc  in  1  resolved redirect (mispredict or taken branch not predicted).
Result  in  ADDR_W  redirect target.
Update_En  in  1  BTB update strobe from execute.
Update_PC  in  ADDR_W  address of the resolved branch.
Update_Target  in  ADDR_W  resolved branch target.
Update_Taken  in  1  resolved branch direction.
PC  out  ADDR_W  current fetch address.
PC_Plus_4  out  ADDR_W  PC + INC.
Pred_Taken  out  1  BTB predicts the current PC taken.
Pred_Target  out  ADDR_W  predicted target; valid when Pred_Taken = 1.
Redirect_Count  out  32  performance counter; see Optional Feature.

Behaviour:
- Reset low: PC = RESET_PC immediately. All BTB valid bits = 0. All counters = 2'b00. Redirect_Count = 0. Tag/target arrays need not be reset.
- PC_Plus_4 = PC + INC, combinational, modulo 2^ADDR_W; wraps 0xFFFFFFFC -> 0x0.
- BTB lookup is combinational on PC:
  - index = PC[IDX_W+1:2]; tag = PC[ADDR_W-1:IDX_W+2].
  - hit = valid & tag match.
  - Pred_Taken = hit & ctr[1]; Pred_Target = stored target. Pred_Target = 0 on a miss.
- Next-PC priority, registered at the rising edge:
  1. PCSrc -> Result. Takes precedence over Stall.
  2. Stall -> PC (hold).
  3. Pred_Taken -> Pred_Target.
  4. Otherwise PC_Plus_4.
- Bits [1:0] of every loaded PC are forced to 0 (word alignment).
- Redirect latency: one cycle. PCSrc is sampled at edge N; PC = Result at edge N.
- BTB update on Update_En at the rising edge; entry at Update_PC index:
  - Valid and tag match: ctr increments (Update_Taken = 1) or decrements (Update_Taken = 0), saturating at 2'b11 and 2'b00. Target is written only when taken.
  - Miss and Update_Taken = 1: allocate. valid = 1, tag and target written, ctr = 2'b10. Replaces any existing entry at that index.
  - Miss and Update_Taken = 0: no change.
- Update and lookup on the same index in the same cycle: the lookup sees old contents. The new contents are visible from the next cycle. No bypass.
- Stall does not block BTB updates.
- Reset asserted mid-operation: overrides everything asynchronously. Any pending update is discarded.

Optional Feature:
- Macro PC_PERF_CNT_EN.
- Defined: Redirect_Count increments by 1 on each rising edge with PCSrc = 1, including stalled cycles. Saturates at 32'hFFFFFFFF. Cleared by reset.
- Undefined: Redirect_Count is tied to 0 and no counter flops are generated. All other behaviour is identical.

Test Plan:
Defaults throughout: RESET_PC = 0, INC = 4, BTB_DEPTH = 16 (index = PC[5:2]).
- Reset low 2 cycles, then release -> PC = 0x0 and PC_Plus_4 = 0x4 during reset. After release PC steps 0x4, 0x8, 0xC. Pred_Taken = 0 throughout.
- PCSrc = 1 with Result = 32'h2914AB4E for one cycle -> PC = 0x2914AB4C, then 0x2914AB50. Redirect_Count = 1 with the macro defined, 0 without.
- Update_En with Update_PC = 0x10, Update_Target = 0x100, Update_Taken = 1, then run from 0 -> at PC = 0x10: Pred_Taken = 1, Pred_Target = 0x100. Next PC = 0x100.
- After the allocation above, two not-taken updates to 0x10 -> ctr goes 10 -> 01 -> 00. PC = 0x10 then predicts not taken; next PC = 0x14. PC = 0x50 (same index 4, different tag) -> no hit.
- Stall = 1 at PC = 0x8 for 3 cycles -> PC holds 0x8. Stall = 1 together with PCSrc = 1 and Result = 0x40 -> PC = 0x40.
- Reset low asynchronously mid-cycle at PC = 0x100 with a trained entry at 0x10 -> PC = 0x0 immediately, without waiting for CLK. After release, PC = 0x10 gives Pred_Taken = 0 and next PC = 0x14.
